regfile_write_arbiter: RTL and testbench

//   Shares the single register-file write port between the in-order pipeline write-back

---
 rtl/regfile_write_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the register-file write port between pipeline WB (priority)
//            and a FIFO of multi-cycle results. Optional RFWA_PERF_EN: stall_cnt.
// Revision : 1.0
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
`ifdef RFWA_PERF_EN
    output logic [15:0]       stall_cnt,
`endif
    input  logic [ADDR_W-1:0] q_addr1,
    input  logic [ADDR_W-1:0] q_addr2,
    output logic              pend1,
    output logic              pend2
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_live;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               r_rf_we;
    logic [ADDR_W-1:0]  r_rf_waddr;
    logic [DATA_W-1:0]  r_rf_wdata;

    logic               w_wb_req;
    logic               w_push;
    logic               w_enq;
    logic               w_enq_live;
    logic               w_empty;
    logic               w_pop;
    logic [DEPTH-1:0]   w_hit1;
    logic [DEPTH-1:0]   w_hit2;

    assign mc_ready   = (r_count != c_FULL);
    assign w_empty    = (r_count == '0);
    assign w_wb_req   = wb_valid && (wb_addr != '0);
    assign w_push     = mc_valid && mc_ready;
    // Address-0 results complete the handshake but are never stored.
    assign w_enq      = w_push && (mc_addr != '0);
    // A same-cycle WB to the same register is younger, so the entry starts dead.
    assign w_enq_live = !(w_wb_req && (wb_addr == mc_addr));
    assign w_pop      = !w_wb_req && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_live   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wb_req && (r_addr[i] == wb_addr)) begin
                    r_live[i] <= 1'b0;
                end
            end
            // Live bit cleared on pop so live always implies occupied.
            if (w_pop) begin
                r_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + 1'b1;
            end
            if (w_enq) begin
                r_addr[r_wr_ptr] <= mc_addr;
                r_data[r_wr_ptr] <= mc_data;
                r_live[r_wr_ptr] <= w_enq_live;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (w_wb_req) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= wb_addr;
            r_rf_wdata <= wb_data;
        end else if (w_pop) begin
            r_rf_we    <= r_live[r_rd_ptr];
            r_rf_waddr <= r_addr[r_rd_ptr];
            r_rf_wdata <= r_data[r_rd_ptr];
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign w_hit1[gi] = r_live[gi] && (r_addr[gi] == q_addr1);
        assign w_hit2[gi] = r_live[gi] && (r_addr[gi] == q_addr2);
    end

    assign pend1 = (q_addr1 != '0) && ((|w_hit1) || (r_rf_we && (r_rf_waddr == q_addr1)));
    assign pend2 = (q_addr2 != '0) && ((|w_hit2) || (r_rf_we && (r_rf_waddr == q_addr2)));

`ifdef RFWA_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_wb_req && !w_empty && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Randomized bench for regfile_write_arbiter against a queue model.
// Revision : 1.0
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          mc_valid;
    logic          mc_ready;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] q_addr1;
    logic [AW-1:0] q_addr2;
    logic          pend1;
    logic          pend2;
`ifdef RFWA_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .mc_valid (mc_valid),
        .mc_ready (mc_ready),
        .mc_addr  (mc_addr),
        .mc_data  (mc_data),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
`ifdef RFWA_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .q_addr1  (q_addr1),
        .q_addr2  (q_addr2),
        .pend1    (pend1),
        .pend2    (pend2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            live;
    } ent_t;

    ent_t          m_q[$];
    bit            m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_stall;
    int            n_chk;
    int            n_bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_pend(input logic [AW-1:0] q);
        bit p;
        p = m_we && (m_waddr == q);
        foreach (m_q[i]) if (m_q[i].live && m_q[i].a == q) p = 1'b1;
        return (q != 0) && p;
    endfunction

    task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input logic [AW-1:0] q1, input logic [AW-1:0] q2);
        bit   wreq;
        bit   acc;
        ent_t h;
        ent_t e;
        @(negedge clk);
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        mc_valid = mv; mc_addr = ma; mc_data = md;
        q_addr1  = q1; q_addr2 = q2;
        #1;
        chk("mc_ready", mc_ready, m_q.size() < DEPTH);
        chk("pend1", pend1, m_pend(q1));
        chk("pend2", pend2, m_pend(q2));
        wreq = wv && (wa != 0);
        acc  = mv && (m_q.size() < DEPTH);
        if (wreq && m_q.size() > 0 && m_stall < 16'hFFFF) m_stall++;
        if (wreq) begin
            m_we = 1'b1; m_waddr = wa; m_wdata = wd;
        end else if (m_q.size() > 0) begin
            h = m_q.pop_front();
            m_we = h.live;
            if (h.live) begin
                m_waddr = h.a; m_wdata = h.d;
            end
        end else begin
            m_we = 1'b0;
        end
        if (wreq) foreach (m_q[i]) if (m_q[i].a == wa) m_q[i].live = 1'b0;
        if (acc && ma != 0) begin
            e.a = ma; e.d = md; e.live = !(wreq && wa == ma);
            m_q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_waddr", rf_waddr, m_waddr);
            chk("rf_wdata", rf_wdata, m_wdata);
        end
`ifdef RFWA_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        wb_valid = 1'b0; mc_valid = 1'b0;
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_mc_ready", mc_ready, 1'b1);
        chk("rst_pend1", pend1, 1'b0);
        chk("rst_pend2", pend2, 1'b0);
`ifdef RFWA_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        m_q.delete();
        m_we = 1'b0; m_stall = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_phase(input int cycles, input int busy_pct);
        for (int c = 0; c < cycles; c++) begin
            step($urandom_range(0, 99) < busy_pct, AW'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        n_chk = 0; n_bad = 0;
        m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_stall = 0;
        rst_n = 1'b1;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
        q_addr1 = '0; q_addr2 = '0;
        do_reset();

        // WB priority over a queued result; queued write lands after WB goes idle
        step(1, 3, 32'h11, 1, 5, 32'h22, 5, 3);
        for (int i = 0; i < 4; i++) step(1, 3, 32'h11, 0, 0, 0, 5, 3);
        step(0, 0, 0, 0, 0, 0, 5, 3);
        step(0, 0, 0, 0, 0, 0, 5, 3);

        // WAW squash of a queued entry
        step(1, 3, 32'h1, 1, 7, 32'hAA, 7, 0);
        step(1, 7, 32'hBB, 0, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 0, 7, 0);

        // Full FIFO back-pressure while WB busy
        for (int i = 0; i < 6; i++) step(1, 4, i, 1, AW'(8 + i), 32'h100 + i, 8, 9);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 8, 9);

        // Zero register on both sides
        step(1, 0, 32'h5, 1, 0, 32'h6, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        rand_phase(800, 85);
        rand_phase(800, 30);

        // Reset with two live entries queued
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 32'h1, 1, 5, 32'h55, 5, 6);
        step(1, 3, 32'h2, 1, 6, 32'h66, 5, 6);
        step(1, 3, 32'h3, 0, 0, 0, 5, 6);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 5, 6);

        rand_phase(1000, 60);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
